ucca_violation_ctrl: RTL



---
 rtl/ucca_pkg.sv | 33 +++
 rtl/ucca_violation_ctrl_if.sv | 34 +++
 rtl/ucca_viol_regs.sv | 123 ++++++++++++
 rtl/ucca_violation_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/ucca_pkg.sv
// ----------------------------------------------------------------------------
// ucca_pkg
// Shared definitions for the UCCA violation controller: FSM state encoding,
// register window offsets, STATUS bit positions and the saturating episode
// counter helper.
// ----------------------------------------------------------------------------
package ucca_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Byte offsets of the 16-bit registers inside the window.
    localparam logic [15:0] STATUS_OFF     = 16'd0;
    localparam logic [15:0] VIOL_PC_OFF    = 16'd2;
    localparam logic [15:0] VIOL_COUNT_OFF = 16'd4;

    // STATUS bit layout. Bits above STATUS_BITS-1 always read as zero.
    localparam int STATUS_STACK_BIT  = 0;
    localparam int STATUS_RETURN_BIT = 1;
    localparam int STATUS_OVF_BIT    = 2;
    localparam int STATUS_BITS       = 3;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    // Episode counter increment that sticks at the maximum value.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == COUNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/ucca_violation_ctrl_if.sv
// ----------------------------------------------------------------------------
// ucca_violation_ctrl_if
// Peripheral data bus used to reach the violation record window.
//   data_en   access strobe
//   data_wr   write qualifier (0 = read)
//   data_addr byte address (bit 0 ignored by the slave)
//   data_din  write data
//   data_dout registered read data, zero when no read hit the window
// ----------------------------------------------------------------------------
interface ucca_violation_ctrl_if;

    logic        data_en;
    logic        data_wr;
    logic [15:0] data_addr;
    logic [15:0] data_din;
    logic [15:0] data_dout;

    modport master (
        output data_en,
        output data_wr,
        output data_addr,
        output data_din,
        input  data_dout
    );

    modport slave (
        input  data_en,
        input  data_wr,
        input  data_addr,
        input  data_din,
        output data_dout
    );

endinterface

// File: rtl/ucca_viol_regs.sv
// ----------------------------------------------------------------------------
// ucca_viol_regs
// Sticky violation record registers and their bus window.
//   clk, srst        clock and synchronous active-high reset
//   bus              peripheral data bus (slave side)
//   outside_ucc      pc is outside the UCC region; writes are only honoured then
//   is_idle          controller FSM is in IDLE; writes are only honoured then
//   episode_start    a new violation episode begins on this edge
//   stack_reset,
//   return_reset     raw violation request lines, ORed into the cause bits
//   pc               program counter captured at episode start
//   viol_cause       live sticky cause bits {return, stack}
// Registers: STATUS (W1C on [2:0]), VIOL_PC (read-only), VIOL_COUNT
// (any write clears, saturating increment per episode).
// ----------------------------------------------------------------------------
module ucca_viol_regs
    import ucca_pkg::*;
#(
    parameter logic [15:0] CONF_BASE = 16'h0170
) (
    input  logic                        clk,
    input  logic                        srst,
    ucca_violation_ctrl_if.slave        bus,
    input  logic                        outside_ucc,
    input  logic                        is_idle,
    input  logic                        episode_start,
    input  logic                        stack_reset,
    input  logic                        return_reset,
    input  logic [15:0]                 pc,
    output logic [1:0]                  viol_cause
);

    logic [STATUS_BITS-1:0] status_reg;
    logic [STATUS_BITS-1:0] status_next;
    logic [STATUS_BITS-1:0] set_vec;
    logic [STATUS_BITS-1:0] clr_vec;
    logic [15:0]            pc_reg;
    logic [15:0]            pc_next;
    logic [15:0]            count_reg;
    logic [15:0]            count_next;
    logic [15:0]            count_base;
    logic [15:0]            dout_reg;
    logic [15:0]            dout_next;

    logic [15:0] word_addr;
    logic        hit_status;
    logic        hit_pc;
    logic        hit_count;
    logic        rd_ok;
    logic        wr_ok;
    logic        wr_status;
    logic        wr_count;
    logic        unused_bits;

    // Address bit 0 is ignored so byte and word addresses decode alike.
    assign word_addr  = {bus.data_addr[15:1], 1'b0};
    assign hit_status = (word_addr == CONF_BASE + STATUS_OFF);
    assign hit_pc     = (word_addr == CONF_BASE + VIOL_PC_OFF);
    assign hit_count  = (word_addr == CONF_BASE + VIOL_COUNT_OFF);

    assign rd_ok = bus.data_en & ~bus.data_wr;
    // Code running inside the UCC, or an episode in progress, must not be
    // able to wipe the evidence.
    assign wr_ok     = bus.data_en & bus.data_wr & outside_ucc & is_idle;
    assign wr_status = wr_ok & hit_status;
    assign wr_count  = wr_ok & hit_count;

    assign unused_bits = ^{bus.data_din[15:STATUS_BITS], bus.data_addr[0]};

    // Set sources; an episode that sets a bit beats a same-cycle W1C.
    always_comb begin
        set_vec                    = '0;
        set_vec[STATUS_STACK_BIT]  = stack_reset;
        set_vec[STATUS_RETURN_BIT] = return_reset;
        set_vec[STATUS_OVF_BIT]    = episode_start & (count_reg == COUNT_MAX);
    end

    assign clr_vec = wr_status ? bus.data_din[STATUS_BITS-1:0] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < STATUS_BITS; gi++) begin : g_status
            assign status_next[gi] = (status_reg[gi] & ~clr_vec[gi]) | set_vec[gi];
        end
    endgenerate

    // A clear and an episode start on the same edge leave the count at 1.
    assign count_base = wr_count ? 16'd0 : count_reg;
    assign count_next = episode_start ? sat_inc(count_base) : count_base;
    assign pc_next    = episode_start ? pc : pc_reg;

    // Read data reflects register contents before this edge's updates.
    always_comb begin
        dout_next = 16'd0;
        if (rd_ok) begin
            if (hit_status) begin
                dout_next = {{(16 - STATUS_BITS){1'b0}}, status_reg};
            end else if (hit_pc) begin
                dout_next = pc_reg;
            end else if (hit_count) begin
                dout_next = count_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            status_reg <= '0;
            pc_reg     <= 16'd0;
            count_reg  <= 16'd0;
            dout_reg   <= 16'd0;
        end else begin
            status_reg <= status_next;
            pc_reg     <= pc_next;
            count_reg  <= count_next;
            dout_reg   <= dout_next;
        end
    end

    assign bus.data_dout = dout_reg;
    assign viol_cause    = status_reg[STATUS_RETURN_BIT:STATUS_STACK_BIT];

endmodule

// File: rtl/ucca_violation_ctrl.sv
// ----------------------------------------------------------------------------
// ucca_violation_ctrl
// Turns UCCA monitor violation requests into fixed-length core reset pulses
// and keeps sticky records (cause, PC, episode count) that survive the pulse.
//   clk           system clock
//   system_reset  power-on reset, synchronous active-high (only reset here)
//   stack_reset   violation request, stack protection monitor (level)
//   return_reset  violation request, return integrity monitor (level)
//   pc            current program counter
//   outside_ucc   pc is outside the UCC region
//   bus           peripheral data bus (slave) for the record window
//   reset         core reset request, HOLD_CYCLES cycles per episode
//   viol_cause    live sticky cause bits {return, stack}
//   in_hold       high while the reset pulse is being held
// ----------------------------------------------------------------------------
module ucca_violation_ctrl
    import ucca_pkg::*;
#(
    parameter int          HOLD_CYCLES = 4,
    parameter logic [15:0] CONF_BASE   = 16'h0170
) (
    input  logic                 clk,
    input  logic                 system_reset,
    input  logic                 stack_reset,
    input  logic                 return_reset,
    input  logic [15:0]          pc,
    input  logic                 outside_ucc,
    ucca_violation_ctrl_if.slave bus,
    output logic                 reset,
    output logic [1:0]           viol_cause,
    output logic                 in_hold
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] cnt_reg;
    logic [7:0] cnt_next;
    logic       reset_reg;
    logic       in_hold_reg;
    logic       viol;
    logic       episode_start;

    assign viol = stack_reset | return_reset;

    // HOLD lasts HOLD_CYCLES cycles (counter HOLD_CYCLES-1 down to 0).
    // DRAIN blocks a stuck request line from retriggering until it drops.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        episode_start = 1'b0;
        case (state_reg)
            IDLE: begin
                if (viol) begin
                    state_next    = HOLD;
                    cnt_next      = HOLD_LOAD;
                    episode_start = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_reg == 8'd0) begin
                    state_next = DRAIN;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            DRAIN: begin
                if (!viol) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (system_reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= 8'd0;
            reset_reg   <= 1'b0;
            in_hold_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            reset_reg   <= (state_next == HOLD);
            in_hold_reg <= (state_next == HOLD);
        end
    end

    assign reset   = reset_reg;
    assign in_hold = in_hold_reg;

    ucca_viol_regs #(
        .CONF_BASE(CONF_BASE)
    ) u_regs (
        .clk          (clk),
        .srst         (system_reset),
        .bus          (bus),
        .outside_ucc  (outside_ucc),
        .is_idle      (state_reg == IDLE),
        .episode_start(episode_start),
        .stack_reset  (stack_reset),
        .return_reset (return_reset),
        .pc           (pc),
        .viol_cause   (viol_cause)
    );

endmodule
